// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready handshake, optional one-entry skid
// buffer (registered in_ready) and flush that squashes held entries and the input.
module ex_mem_pipe_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned TARGET_W   = 8,
  parameter int unsigned SKID       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic                  in_mem_write,
  input  logic                  in_mem_read,
  input  logic                  in_branch_taken,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_write_data,
  input  logic [REG_ADDR_W-1:0] in_write_reg,
  input  logic [DATA_W-1:0]     in_branch_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_reg_write,
  output logic                  out_mem_to_reg,
  output logic                  out_mem_write,
  output logic                  out_mem_read,
  output logic                  out_branch_taken,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [DATA_W-1:0]     out_write_data,
  output logic [REG_ADDR_W-1:0] out_write_reg,
  output logic [TARGET_W-1:0]   out_branch_target,
  output logic                  out_skid_full
);

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  mem_read;
    logic                  branch_taken;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     write_data;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [TARGET_W-1:0]   branch_target;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   accept;
  logic   pop;
  logic   unused_target_hi;

  // Only the low TARGET_W bits of the target are carried downstream.
  assign unused_target_hi = ^in_branch_target;

  assign in_entry = '{
    reg_write:     in_reg_write,
    mem_to_reg:    in_mem_to_reg,
    mem_write:     in_mem_write,
    mem_read:      in_mem_read,
    branch_taken:  in_branch_taken,
    alu_result:    in_alu_result,
    write_data:    in_write_data,
    write_reg:     in_write_reg,
    branch_target: in_branch_target[TARGET_W-1:0]
  };

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID != 0) ? (~reset & (state_q != TWO))
                                 : (~reset & (~out_valid | out_ready));
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            // Only reachable with SKID!=0: without a skid, in_ready requires a pop.
            state_d = TWO;
            skid_d  = in_entry;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_reg_write     = out_valid & main_q.reg_write;
  assign out_mem_to_reg    = main_q.mem_to_reg;
  assign out_mem_write     = out_valid & main_q.mem_write;
  assign out_mem_read      = out_valid & main_q.mem_read;
  assign out_branch_taken  = out_valid & main_q.branch_taken;
  assign out_alu_result    = main_q.alu_result;
  assign out_write_data    = main_q.write_data;
  assign out_write_reg     = main_q.write_reg;
  assign out_branch_target = main_q.branch_target;
  assign out_skid_full     = (SKID != 0) && (state_q == TWO);

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: SKID=1 and SKID=0 instances share stimulus; each is
// checked every cycle against a queue-based model plus directed literal checks.
module tb_ex_mem_pipe_stage;

  typedef struct packed {
    logic        rw, mtr, mw, mr, bt;
    logic [31:0] alu, wd;
    logic [4:0]  wreg;
    logic [31:0] tgt;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, flush, in_valid, out_ready;
  op_t  in_op;

  logic        ir[2], ov[2], sf[2], orw[2], omtr[2], omw[2], omr[2], obt[2];
  logic [31:0] oalu[2], owd[2];
  logic [4:0]  owr[2];
  logic [7:0]  otgt[2];

  int  n_cmp = 0;
  int  n_fail = 0;
  op_t mq[2][$];

  ex_mem_pipe_stage #(.DATA_W(32), .REG_ADDR_W(5), .TARGET_W(8), .SKID(1)) u_skid1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_reg_write(in_op.rw), .in_mem_to_reg(in_op.mtr), .in_mem_write(in_op.mw),
    .in_mem_read(in_op.mr), .in_branch_taken(in_op.bt), .in_alu_result(in_op.alu),
    .in_write_data(in_op.wd), .in_write_reg(in_op.wreg), .in_branch_target(in_op.tgt),
    .out_valid(ov[1]), .out_ready(out_ready), .out_reg_write(orw[1]),
    .out_mem_to_reg(omtr[1]), .out_mem_write(omw[1]), .out_mem_read(omr[1]),
    .out_branch_taken(obt[1]), .out_alu_result(oalu[1]), .out_write_data(owd[1]),
    .out_write_reg(owr[1]), .out_branch_target(otgt[1]), .out_skid_full(sf[1])
  );

  ex_mem_pipe_stage #(.DATA_W(32), .REG_ADDR_W(5), .TARGET_W(8), .SKID(0)) u_skid0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_reg_write(in_op.rw), .in_mem_to_reg(in_op.mtr), .in_mem_write(in_op.mw),
    .in_mem_read(in_op.mr), .in_branch_taken(in_op.bt), .in_alu_result(in_op.alu),
    .in_write_data(in_op.wd), .in_write_reg(in_op.wreg), .in_branch_target(in_op.tgt),
    .out_valid(ov[0]), .out_ready(out_ready), .out_reg_write(orw[0]),
    .out_mem_to_reg(omtr[0]), .out_mem_write(omw[0]), .out_mem_read(omr[0]),
    .out_branch_taken(obt[0]), .out_alu_result(oalu[0]), .out_write_data(owd[0]),
    .out_write_reg(owr[0]), .out_branch_target(otgt[0]), .out_skid_full(sf[0])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [skid=%0d]: got 0x%0h expected 0x%0h (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  // Capacity 2 with skid (ready while fewer than 2 held), else 1 with pass-through ready.
  function automatic bit m_ready(input int k);
    if (reset) return 1'b0;
    if (k == 1) return mq[1].size() < 2;
    return (mq[0].size() == 0) || out_ready;
  endfunction

  task automatic compare(input int k);
    bit  ev;
    op_t o;
    ev = mq[k].size() > 0;
    chk("out_valid", k, ov[k], ev);
    chk("in_ready", k, ir[k], m_ready(k));
    chk("out_skid_full", k, sf[k], (k == 1) && (mq[k].size() == 2));
    if (ev) begin
      o = mq[k][0];
      chk("out_reg_write", k, orw[k], o.rw);
      chk("out_mem_to_reg", k, omtr[k], o.mtr);
      chk("out_mem_write", k, omw[k], o.mw);
      chk("out_mem_read", k, omr[k], o.mr);
      chk("out_branch_taken", k, obt[k], o.bt);
      chk("out_alu_result", k, oalu[k], o.alu);
      chk("out_write_data", k, owd[k], o.wd);
      chk("out_write_reg", k, owr[k], o.wreg);
      chk("out_branch_target", k, otgt[k], o.tgt % 256);
    end else begin
      chk("idle_ctrl", k, {orw[k], omw[k], omr[k], obt[k]}, 0);
    end
  endtask

  task automatic step(input int k);
    bit r, p, a;
    r = m_ready(k);
    p = (mq[k].size() > 0) && out_ready;
    a = in_valid && r && !flush;
    if (reset || flush) begin
      mq[k].delete();
    end else begin
      if (p) void'(mq[k].pop_front());
      if (a) mq[k].push_back(in_op);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare(0);
    compare(1);
    @(posedge clk);
    step(0);
    step(1);
    #1;
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.rw   = 1'($urandom);
    o.mtr  = 1'($urandom);
    o.mw   = 1'($urandom);
    o.mr   = 1'($urandom);
    o.bt   = 1'($urandom);
    o.alu  = $urandom;
    o.wd   = $urandom;
    o.wreg = 5'($urandom);
    o.tgt  = $urandom;
    return o;
  endfunction

  function automatic op_t mk(input logic [31:0] alu, input logic [4:0] wreg,
                             input logic mw, input logic [31:0] tgt);
    op_t o;
    o = '0;
    o.rw = 1'b1;
    o.mw = mw;
    o.alu = alu;
    o.wd = alu ^ 32'h5555_0000;
    o.wreg = wreg;
    o.tgt = tgt;
    return o;
  endfunction

  initial begin
    int bias;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_op = mk(32'h99, 5'd9, 1'b1, 32'h1234);
    @(posedge clk); #1;

    // Reset held with in_valid asserted
    cycle();
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", k, ir[k], 0);
      chk("rst_out_valid", k, ov[k], 0);
      chk("rst_alu", k, oalu[k], 0);
      chk("rst_wdata", k, owd[k], 0);
      chk("rst_wreg", k, owr[k], 0);
      chk("rst_target", k, otgt[k], 0);
      chk("rst_ctrl", k, {orw[k], omtr[k], omw[k], omr[k], obt[k], sf[k]}, 0);
    end
    reset = 1'b0; in_valid = 1'b0;
    cycle();

    // Back-to-back stream, 1-cycle latency
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_op = mk(32'h10 + i, 5'(i + 1), 1'b0, 32'hDEAD_BEEF);
      cycle();
      chk("stream_alu", 1, oalu[1], 32'h10 + i);
      chk("stream_alu", 0, oalu[0], 32'h10 + i);
      chk("stream_valid", 1, ov[1], 1);
      chk("target_trunc", 1, otgt[1], 32'hEF);
      chk("target_trunc", 0, otgt[0], 32'hEF);
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_drained", 1, ov[1], 0);

    // Stall: A, B fill the SKID=1 stage, C is held off
    out_ready = 1'b0; in_valid = 1'b1;
    in_op = mk(32'hA0, 5'd3, 1'b1, 32'h0); cycle();
    in_op = mk(32'hB0, 5'd7, 1'b1, 32'h0); cycle();
    in_op = mk(32'hC0, 5'd11, 1'b1, 32'h0); cycle();
    chk("stall_skid_full", 1, sf[1], 1);
    chk("stall_in_ready", 1, ir[1], 0);
    chk("stall_head", 1, owr[1], 3);
    chk("stall_head", 0, owr[0], 3);
    chk("stall_in_ready", 0, ir[0], 0);
    out_ready = 1'b1;
    cycle();
    chk("drain_B", 1, owr[1], 7);
    cycle();
    chk("drain_C", 1, owr[1], 11);
    in_valid = 1'b0;
    cycle();
    chk("drain_done", 1, ov[1], 0);

    // Flush from the full (two-entry) state with a new input present
    out_ready = 1'b0; in_valid = 1'b1;
    in_op = mk(32'h1, 5'd1, 1'b1, 32'h0); cycle();
    in_op = mk(32'h2, 5'd2, 1'b1, 32'h0); cycle();
    chk("pre_flush_full", 1, sf[1], 1);
    in_op = mk(32'h3, 5'd3, 1'b1, 32'h0);
    flush = 1'b1;
    cycle();
    chk("flush_valid", 1, ov[1], 0);
    chk("flush_mem_write", 1, omw[1], 0);
    chk("flush_in_ready", 1, ir[1], 1);
    chk("flush_valid", 0, ov[0], 0);
    flush = 1'b0; in_valid = 1'b0;
    cycle();

    // Randomized traffic with varying back-pressure, rare flush and reset
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 3)
        0: bias = 25;
        1: bias = 60;
        default: bias = 95;
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 99) < bias);
      flush     = ($urandom_range(0, 24) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      in_op     = rand_op();
      cycle();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
